pipe_stage_chain: RTL
=====================

Name: pipe_stage_chain

Overview:
- Parametrised successor to the fixed REG/EX/MEM/WB control-bundle pipeline in the 16-bit core.
- Carries an instruction/control word through STAGES pipeline registers, each with a valid bit.
- Supports per-stage flush masks, an external stall, and a counted multi-cycle stall FSM.
- Inserts bubbles at a configurable stall point and counts the bubbles inserted; replaces the hard-wired REG_Mask/EX_Mask/MEM_Mask logic.

Parameters:
- WIDTH, 16, width of the word carried per stage.
- STAGES, 4, number of pipeline registers; legal range 2..8.
- STALL_STAGE, 1, first stage that receives a bubble during a stall; stages below it hold. Legal range 1..STAGES-1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- in_word  in  WIDTH  word entering stage 0.
- in_valid  in  1  in_word is a real instruction.
- in_ready  out  1  stage 0 accepts in_word this cycle.
- stall  in  1  level external stall request.
- stall_req  in  1  one-cycle pulse that starts a counted stall.
- stall_len  in  4  number of stall cycles requested with stall_req.
- flush  in  STAGES  per-stage squash mask; bit k applies to stage k.
- stage_word  out  STAGES*WIDTH  all stage registers; stage k occupies bits [k*WIDTH +: WIDTH].
- stage_valid  out  STAGES  valid bit of each stage.
- out_word  out  WIDTH  equals stage STAGES-1 word.
- out_valid  out  1  equals stage STAGES-1 valid.
- stalled  out  1  effective stall is active this cycle.
- bubble_count  out  16  saturating count of stall-inserted bubbles.

Behaviour:
- Reset (reset==0 at a clk edge):
  - all stage words and valids become 0, bubble_count becomes 0, FSM goes to RUN, hold counter becomes 0.
  - Reset overrides every other input, including mid-HOLD.
- FSM states: RUN and HOLD.
  - RUN -> HOLD when stall_req==1 and stall_len!=0; hold counter loads stall_len.
  - HOLD: counter decrements each cycle. When the counter is 1, the next state is RUN.
  - A HOLD entered with stall_len=N therefore lasts exactly N cycles.
  - stall_req in HOLD is ignored. stall_req with stall_len==0 is ignored.
- Effective stall: eff = stall OR (state==HOLD). The stalled output equals eff combinationally.
- in_ready = NOT eff, combinational.
- Advance cycle (eff==0):
  - stage0 <= {in_word, in_valid}.
  - stage k <= stage k-1 for k = 1..STAGES-1.
- Stall cycle (eff==1):
  - stages 0..STALL_STAGE-1 hold their contents.
  - stage STALL_STAGE <= bubble (word 0, valid 0).
  - stages above STALL_STAGE advance normally.
  - in_word is dropped. The source must hold it until in_ready==1.
- Flush: if flush[k]==1 at an edge, stage k becomes word 0, valid 0, whatever it would otherwise load or hold.
  - Flush takes priority over both advance and hold.
  - Multiple flush bits may be set in the same cycle.
- bubble_count:
  - increments by 1 on each stall-cycle edge whose previous contents of stage STALL_STAGE-1 had valid==1.
  - A bubble injected behind an empty stage is not counted.
  - Flush does not count.
  - Saturates at 16'hFFFF; never wraps.
- Latency: a word accepted with in_ready==1 reaches out_word after STAGES edges, plus one edge per stall cycle it sits in a holding stage.
- Simultaneous events:
  - stall and stall_req together: eff==1 this cycle, and HOLD still starts next cycle.
  - When the external stall drops during HOLD, the pipeline stays stalled until the counter expires.
- All outputs except in_ready and stalled are registered.

Test Plan:
- Reset and fill (WIDTH=16, STAGES=4, STALL_STAGE=1):
  - Hold reset low for 2 edges -> all stage_valid=0, out_word=0, bubble_count=0.
  - Release reset and feed 16'h1001..16'h1004 valid on consecutive cycles -> out_word=16'h1001 with out_valid=1 on the 4th edge after the first accept, then 1002, 1003, 1004 on following edges.
- External stall:
  - Stream 16'h2001..16'h2006 and assert stall for 2 cycles while 16'h2003 is in stage 0.
  - Required: in_ready=0 for those 2 cycles, stage 0 holds 16'h2003, stage 1 shows 2 bubbles (valid 0).
  - Output order 2001, 2002, bubble, bubble, 2003, ... with no loss or duplication; bubble_count=2.
- Counted stall: stall_req=1 with stall_len=3 in RUN -> stalled=1 for exactly 3 cycles starting the next cycle, then RUN; bubble_count increases by 3 when stage 0 is valid.
- Flush priority:
  - Assert flush=4'b0011 while stalled with stage 0 valid -> stages 0 and 1 become valid=0, word 0 on that edge.
  - bubble_count is unchanged for the flushed stage; stage 2 and stage 3 advance.
- Reset mid-HOLD: stall_req with stall_len=8, then reset low after 2 cycles -> FSM RUN, stalled=0, all valids 0, bubble_count=0 on the reset edge.
- Saturation: with bubble_count forced near 16'hFFFE via a long stall on valid stage 0 -> counter reaches 16'hFFFF and stays there.

Source files
------------

// File: rtl/pipe_stage_chain_if.sv
// Bundle of the pipeline's control, input and observation signals.
// The master modport is the source/observer side; the slave modport is the pipeline itself.
interface pipe_stage_chain_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
);
  logic [WIDTH-1:0]        in_word;
  logic                    in_valid;
  logic                    in_ready;
  logic                    stall;
  logic                    stall_req;
  logic [3:0]              stall_len;
  logic [STAGES-1:0]       flush;
  logic [STAGES*WIDTH-1:0] stage_word;
  logic [STAGES-1:0]       stage_valid;
  logic [WIDTH-1:0]        out_word;
  logic                    out_valid;
  logic                    stalled;
  logic [15:0]             bubble_count;

  modport master (
    output in_word, in_valid, stall, stall_req, stall_len, flush,
    input  in_ready, stage_word, stage_valid, out_word, out_valid, stalled, bubble_count
  );

  modport slave (
    input  in_word, in_valid, stall, stall_req, stall_len, flush,
    output in_ready, stage_word, stage_valid, out_word, out_valid, stalled, bubble_count
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// Parametrised chain of valid-tagged pipeline registers with flush masks, an external
// stall, a counted multi-cycle stall FSM and a saturating count of inserted bubbles.
module pipe_stage_chain #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned STAGES      = 4,
  parameter int unsigned STALL_STAGE = 1
) (
  input logic               clk,
  input logic               reset,
  pipe_stage_chain_if.slave bus
);

  typedef enum logic [0:0] {StRun, StHold} state_e;

  state_e                  state_q;
  logic [3:0]              hold_cnt_q;
  logic [STAGES*WIDTH-1:0] word_q, word_d;
  logic [STAGES-1:0]       valid_q, valid_d;
  logic [15:0]             bubble_count_q;
  logic                    eff;
  logic                    count_bubble;

  assign eff          = bus.stall | (state_q == StHold);
  assign bus.stalled  = eff;
  assign bus.in_ready = ~eff;

  // A bubble only counts if it displaces a real instruction and is not squashed by flush.
  assign count_bubble = eff & valid_q[STALL_STAGE-1] & ~bus.flush[STALL_STAGE];

  // Next contents of each stage: advance, hold below the stall point, bubble at it; flush wins.
  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    // Stage 0 is always below the stall point, so it only loads when not stalled.
    if (!eff) begin
      word_d[0 +: WIDTH] = bus.in_word;
      valid_d[0]         = bus.in_valid;
    end
    for (int unsigned k = 1; k < STAGES; k++) begin
      if (eff && (k < STALL_STAGE)) begin
        word_d[k*WIDTH +: WIDTH] = word_q[k*WIDTH +: WIDTH];
        valid_d[k]               = valid_q[k];
      end else if (eff && (k == STALL_STAGE)) begin
        word_d[k*WIDTH +: WIDTH] = '0;
        valid_d[k]               = 1'b0;
      end else begin
        word_d[k*WIDTH +: WIDTH] = word_q[(k-1)*WIDTH +: WIDTH];
        valid_d[k]               = valid_q[k-1];
      end
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (bus.flush[k]) begin
        word_d[k*WIDTH +: WIDTH] = '0;
        valid_d[k]               = 1'b0;
      end
    end
  end

  // Stage registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      word_q  <= '0;
      valid_q <= '0;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  // Run/hold FSM: a HOLD entered with length N lasts exactly N cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StRun;
      hold_cnt_q <= 4'd0;
    end else begin
      case (state_q)
        StRun: begin
          if (bus.stall_req && (bus.stall_len != 4'd0)) begin
            state_q    <= StHold;
            hold_cnt_q <= bus.stall_len;
          end
        end
        StHold: begin
          hold_cnt_q <= hold_cnt_q - 4'd1;
          if (hold_cnt_q == 4'd1) begin
            state_q <= StRun;
          end
        end
        default: begin
          state_q    <= StRun;
          hold_cnt_q <= 4'd0;
        end
      endcase
    end
  end

  // Saturating bubble counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bubble_count_q <= 16'd0;
    end else if (count_bubble && (bubble_count_q != 16'hFFFF)) begin
      bubble_count_q <= bubble_count_q + 16'd1;
    end
  end

  assign bus.stage_word   = word_q;
  assign bus.stage_valid  = valid_q;
  assign bus.out_word     = word_q[(STAGES-1)*WIDTH +: WIDTH];
  assign bus.out_valid    = valid_q[STAGES-1];
  assign bus.bubble_count = bubble_count_q;

endmodule
